// File: rtl/regfile_tag.sv
// rtl/regfile_tag.sv - register file with rename tags and busy bits, two combinational read ports
// Optional macro REGFILE_TAG_BYPASS_EN forwards same-cycle commit data to the read ports.
module regfile_tag #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int TAGW = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wn,
  input  logic [TAGW-1:0] wtag,
  input  logic            te,
  input  logic [AW-1:0]   ta,
  input  logic [TAGW-1:0] tt,
  input  logic            flush,
  input  logic            re1,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rn1,
  output logic            rb1,
  output logic [TAGW-1:0] rt1,
  input  logic            re2,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rn2,
  output logic            rb2,
  output logic [TAGW-1:0] rt2
);

  typedef struct packed {
    logic [XLEN-1:0] n;
    logic            b;
    logic [TAGW-1:0] t;
  } rd_t;

  logic [XLEN-1:0] data_q [NREG];
  logic [XLEN-1:0] data_d [NREG];
  logic [TAGW-1:0] tag_q  [NREG];
  logic [TAGW-1:0] tag_d  [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic commit_v;
  logic assign_v;
  logic tag_match;

  always_comb begin
    commit_v  = we && (wa != '0);
    assign_v  = te && (ta != '0);
    tag_match = busy_q[wa] && (tag_q[wa] == wtag);
  end

  // Assign overrides a same-register commit; flush overrides the assign but not the data write.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_v) begin
      data_d[wa] = wn;
      if (tag_match) busy_d[wa] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (assign_v) begin
      busy_d[ta] = 1'b1;
      tag_d[ta]  = tt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  function automatic rd_t rd_port(input logic e, input logic [AW-1:0] a);
    rd_t r;
    r = '0;
    if (rst && e && (a != '0)) begin
      r.n = data_q[a];
      r.b = busy_q[a];
      r.t = tag_q[a];
`ifdef REGFILE_TAG_BYPASS_EN
      if (we && (wa == a)) begin
        r.n = wn;
        if (busy_q[a] && (tag_q[a] == wtag)) r.b = 1'b0;
      end
`endif
    end
    return r;
  endfunction

  rd_t rd1;
  rd_t rd2;

  always_comb begin
    rd1 = rd_port(re1, ra1);
    rd2 = rd_port(re2, ra2);
  end

  assign rn1 = rd1.n;
  assign rb1 = rd1.b;
  assign rt1 = rd1.t;
  assign rn2 = rd2.n;
  assign rb2 = rd2.b;
  assign rt2 = rd2.t;

endmodule

// File: tb/tb_regfile_tag.sv
// tb/tb_regfile_tag.sv - randomized and directed self-checking bench for regfile_tag
module tb_regfile_tag;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int TAGW = 4;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wn;
  logic [TAGW-1:0] wtag;
  logic            te;
  logic [AW-1:0]   ta;
  logic [TAGW-1:0] tt;
  logic            flush;
  logic            re1, re2;
  logic [AW-1:0]   ra1, ra2;
  logic [XLEN-1:0] rn1, rn2;
  logic            rb1, rb2;
  logic [TAGW-1:0] rt1, rt2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit bypass;

  logic [XLEN-1:0] m_data [NREG];
  logic            m_busy [NREG];
  logic [TAGW-1:0] m_tag  [NREG];

  regfile_tag #(.XLEN(XLEN), .NREG(NREG), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .we(we), .wa(wa), .wn(wn), .wtag(wtag),
    .te(te), .ta(ta), .tt(tt), .flush(flush),
    .re1(re1), .ra1(ra1), .rn1(rn1), .rb1(rb1), .rt1(rt1),
    .re2(re2), .ra2(ra2), .rn2(rn2), .rb2(rb2), .rt2(rt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: architectural state plus rules applied as a whole-cycle transaction.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else begin
      int w, t;
      w = int'(wa);
      t = int'(ta);
      if (we && w != 0) begin
        if (m_busy[w] && m_tag[w] == wtag) m_busy[w] = 1'b0;
        m_data[w] = wn;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else if (te && t != 0) begin
        m_busy[t] = 1'b1;
        m_tag[t]  = tt;
      end
    end
  end

  function automatic logic [XLEN+TAGW:0] exp_read(input logic e, input logic [AW-1:0] a);
    logic [XLEN-1:0] n;
    logic            b;
    logic [TAGW-1:0] t;
    int ai;
    ai = int'(a);
    if (!rst || !e || ai == 0) return '0;
    n = m_data[ai];
    b = m_busy[ai];
    t = m_tag[ai];
    if (bypass && we && wa == a) begin
      n = wn;
      if (m_busy[ai] && m_tag[ai] == wtag) b = 1'b0;
    end
    return {n, b, t};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_port1", {rn1, rb1, rt1}, exp_read(re1, ra1));
      chk("model_port2", {rn2, rb2, rt2}, exp_read(re2, ra2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; we = 1'b0; wa = '0; wn = '0; wtag = '0;
    te = 1'b0; ta = '0; tt = '0; flush = 1'b0;
  endtask

  initial begin
`ifdef REGFILE_TAG_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    idle();
    re1 = 1'b0; re2 = 1'b0; ra1 = '0; ra2 = '0;
    rst = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    rst = 1'b1; re1 = 1'b1; re2 = 1'b1;

    for (int a = 0; a < NREG; a++) begin
      ra1 = AW'(a); ra2 = AW'(NREG - 1 - a);
      look();
      chk("reset_read1", {rn1, rb1, rt1}, '0);
      chk("reset_read2", {rn2, rb2, rt2}, '0);
      step();
    end

    te = 1'b1; ta = 5; tt = 3;
    step();
    te = 1'b0; we = 1'b1; wa = 5; wtag = 3; wn = 32'hDEADBEEF; ra1 = 5;
    step();
    we = 1'b0;
    look();
    chk("match_data", rn1, 32'hDEADBEEF);
    chk("match_busy", rb1, 1'b0);
    step();

    te = 1'b1; ta = 7; tt = 1;
    step();
    tt = 2;
    step();
    te = 1'b0; we = 1'b1; wa = 7; wtag = 1; wn = 32'h11;
    step();
    we = 1'b0; ra1 = 7;
    look();
    chk("stale_data", rn1, 32'h11);
    chk("stale_busy", rb1, 1'b1);
    chk("stale_tag", rt1, 4'd2);
    step();

    we = 1'b1; wa = 9; wtag = 4; wn = 32'h55; te = 1'b1; ta = 9; tt = 6; ra1 = 9;
    look();
    chk("simul_pre_busy", rb1, 1'b0);
    chk("simul_pre_data", rn1, bypass ? 32'h55 : 32'h0);
    step();
    idle();
    look();
    chk("simul_data", rn1, 32'h55);
    chk("simul_busy", rb1, 1'b1);
    chk("simul_tag", rt1, 4'd6);
    step();

    we = 1'b1; wa = 0; wn = 32'hFF; te = 1'b1; ta = 0; tt = 9; ra1 = 0;
    step();
    idle();
    look();
    chk("r0_data", rn1, 32'h0);
    chk("r0_busy", rb1, 1'b0);
    te = 1'b1; ta = 3; tt = 1;
    step();
    ta = 4;
    step();
    te = 1'b0; ra1 = 3; ra2 = 4;
    look();
    chk("pre_flush_busy3", rb1, 1'b1);
    chk("pre_flush_busy4", rb2, 1'b1);
    flush = 1'b1; te = 1'b1; ta = 6; tt = 5;
    step();
    idle();
    look();
    chk("flush_busy3", rb1, 1'b0);
    chk("flush_busy4", rb2, 1'b0);
    ra1 = 6;
    look();
    chk("flush_busy6", rb1, 1'b0);

    step();
    we = 1'b1; wa = 2; wn = 32'hA5; ra1 = 2; ra2 = 2;
    look();
    chk("bypass_same1", rn1, bypass ? 32'hA5 : 32'h0);
    chk("bypass_same2", rn2, bypass ? 32'hA5 : 32'h0);
    step();
    we = 1'b0;
    look();
    chk("bypass_next1", rn1, 32'hA5);
    chk("bypass_next2", rn2, 32'hA5);

    re1 = 1'b0; ra1 = 5;
    look();
    chk("read_disabled", {rn1, rb1, rt1}, '0);
    re1 = 1'b1;
    step();

    te = 1'b1; ta = 10; tt = 7; we = 1'b1; wa = 10; wn = 32'h123; rst = 1'b0;
    step();
    idle();
    ra1 = 10; ra2 = 5;
    look();
    chk("midreset_r10", {rn1, rb1, rt1}, '0);
    chk("midreset_r5", {rn2, rb2, rt2}, '0);
    step();

    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 99) != 0);
      we    = $urandom_range(0, 1);
      wa    = AW'($urandom_range(0, 7));
      wn    = $urandom;
      wtag  = TAGW'($urandom_range(0, 3));
      te    = $urandom_range(0, 1);
      ta    = AW'($urandom_range(0, 7));
      tt    = TAGW'($urandom_range(0, 3));
      flush = ($urandom_range(0, 15) == 0);
      re1   = ($urandom_range(0, 7) != 0);
      re2   = ($urandom_range(0, 7) != 0);
      ra1   = AW'($urandom_range(0, 7));
      ra2   = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      step();
    end

    idle();
    look();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
